// File: rtl/sync_ram_init_if.sv
// sync_ram_init_if: access bus (CS/RWS/Address/DataInput in, DataOutput/Ready/Valid out) for sync_ram_init
interface sync_ram_init_if #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic CS;
  logic RWS;
  logic [ADDR_WIDTH-1:0] Address;
  logic [WIDTH-1:0] DataInput;
  logic [WIDTH-1:0] DataOutput;
  logic Ready;
  logic Valid;
  modport master(output CS, RWS, Address, DataInput, input DataOutput, Ready, Valid);
  modport slave(input CS, RWS, Address, DataInput, output DataOutput, Ready, Valid);
endinterface

// File: rtl/sync_ram_init.sv
// sync_ram_init: self-zeroing 1-cycle sync RAM; ports CLK, Reset (sync, active-low), bus slave (CS/RWS/Address/DataInput -> DataOutput/Ready/Valid); SYNC_RAM_WRITE_THROUGH_EN enables write-through
module sync_ram_init #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic CLK,
  input logic Reset,
  sync_ram_init_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [WIDTH-1:0] dout;
  logic valid, ready, rd, wr, we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [WIDTH-1:0] wd;
  always_ff @(posedge CLK)
    if (!Reset) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= state == INIT ? cnt + ADDR_WIDTH'(1) : cnt;
    end
  always_comb state_n = state == INIT && cnt == '1 ? RUN : state;
  always_comb begin
    ready = state == RUN;
    rd = Reset && ready && bus.CS && !bus.RWS;
    wr = Reset && ready && bus.CS && bus.RWS;
    we = wr || (Reset && state == INIT);
    wa = ready ? bus.Address : cnt;
    wd = ready ? bus.DataInput : '0;
  end
  always_ff @(posedge CLK)
    if (we) mem[wa] <= wd;
  always_ff @(posedge CLK)
    if (!Reset) begin
      dout <= '0;
      valid <= 1'b0;
    end else begin
`ifdef SYNC_RAM_WRITE_THROUGH_EN
      dout <= rd ? mem[bus.Address] : wr ? bus.DataInput : dout;
      valid <= rd || wr;
`else
      dout <= rd ? mem[bus.Address] : dout;
      valid <= rd;
`endif
    end
  assign bus.Ready = ready;
  assign bus.Valid = valid;
  assign bus.DataOutput = dout;
endmodule

// File: doc/sync_ram_init.md
SYNC_RAM_INIT -- requirements
Module: sync_ram_init

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: address width; depth DEPTH = 2**ADDR_WIDTH words, legal range 1..12.
REQ-003 SHALL have port CLK  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port CS  input  1: chip select; an access is requested when CS=1.
REQ-006 SHALL have port RWS  input  1: access type; 1=write, 0=read.
REQ-007 SHALL have port Address  input  ADDR_WIDTH: word address of the access.
REQ-008 SHALL have port DataInput  input  WIDTH: write data.
REQ-009 SHALL have port DataOutput  output  WIDTH: registered read data, always driven, never tri-stated.
REQ-010 SHALL have port Ready  output  1: 1 when the block accepts an access this cycle.
REQ-011 SHALL have port Valid  output  1: 1-cycle pulse marking new data on DataOutput.

Function
REQ-012 SHALL implement a two-state controller: INIT and RUN.
REQ-013 In INIT, SHALL write zero to one word per cycle, using an internal counter from 0 up to DEPTH-1.
REQ-014 SHALL move INIT->RUN on the cycle after the counter=DEPTH-1 write; INIT therefore lasts exactly DEPTH cycles.
REQ-015 SHALL drive Ready=1 only in RUN; Ready is registered, not combinational from CS.
REQ-016 In INIT, SHALL ignore CS/RWS/Address/DataInput completely: no write, no Valid, no queuing.
REQ-017 Accepted access: CS=1 and Ready=1 at a rising edge.
REQ-018 On an accepted write, SHALL store DataInput at Address at that edge; the write is visible to a read accepted on the next edge.
REQ-019 On an accepted read, SHALL load mem[Address] into DataOutput at that edge, with Valid=1 for that following cycle; read latency is 1.
REQ-020 Back-to-back reads on consecutive cycles SHALL each produce Valid; full throughput is one access per cycle.
REQ-021 When there is no accepted read, SHALL keep DataOutput unchanged and set Valid=0.
REQ-022 SHALL treat address wrap-around as natural; all 2**ADDR_WIDTH addresses are legal and there is no out-of-range case.
REQ-023 A read of a word never written since the last reset SHALL return 0, guaranteed by INIT.

Reset
REQ-024 On a rising edge with Reset=0, SHALL enter INIT with counter=0, Ready=0, Valid=0 and DataOutput=0.
REQ-025 Reset asserted during INIT SHALL restart INIT from counter 0.
REQ-026 Reset asserted during RUN SHALL abandon any access presented in that cycle; no write occurs and no Valid follows.
REQ-027 SHALL not clear memory contents directly by reset; clearing happens only through INIT, one word per cycle.
REQ-028 SHALL have no asynchronous state anywhere in the block.

Configuration
REQ-029 SHALL use macro SYNC_RAM_WRITE_THROUGH_EN to control write-through on accepted writes.
REQ-030 With the macro defined, an accepted write SHALL also load DataInput into DataOutput, with Valid=1 on the next cycle.
REQ-031 With the macro undefined, an accepted write SHALL leave DataOutput unchanged and keep Valid=0.

Verification
REQ-032 Reset=0 for 2 cycles, then 1 -> Ready=0 for exactly 8 cycles (defaults), then Ready=1; DataOutput=0 and Valid=0 throughout.
REQ-033 After INIT, read all 8 addresses back-to-back -> 8 consecutive Valid pulses, each with DataOutput=0x00.
REQ-034 Write 0xA5@3, then read @3 on the next cycle -> Valid with DataOutput=0xA5; read @4 -> 0x00.
REQ-035 Hold CS=1, RWS=1, DataInput=0xFF @2 during INIT cycles 0..7 -> after INIT, read @2 returns 0x00.
REQ-036 Write 0x3C@5, then Reset=0 at INIT cycle 4, release, wait for Ready, read @5 -> 0x00; INIT length again 8 cycles.
REQ-037 Write 0x77@1 with the macro defined -> next cycle Valid=1, DataOutput=0x77; with the macro undefined -> Valid=0 and DataOutput unchanged.
